// File: rtl/sysid_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sysid_ctrl_pkg
// Shared definitions for the sysid read controller:
//   - state_e            : controller FSM states
//   - DEFAULT_EXPECTED_ID: default system ID checked at sysid word 0
//   - DEFAULT_EXPECTED_TS: default timestamp checked at sysid word 1
//   - SERVE_COUNT_MAX    : saturation value of the serve counter
//   - sat_inc16()        : saturating 16-bit increment
// ---------------------------------------------------------------------------
package sysid_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT_ID = 2'd0,
        BOOT_TS = 2'd1,
        IDLE    = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd452;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1301991580;
    localparam logic [15:0] SERVE_COUNT_MAX     = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == SERVE_COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sysid_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational from req and the
// stored "last winner"; on a tie the requester that did not win last time
// is chosen. The stored winner only moves when the caller takes the grant
// (advance), so a grant that is not consumed does not disturb fairness.
//   clock   : sole clock
//   reset   : asynchronous active-high reset, makes requester 0 win first tie
//   req     : request vector, bit i = requester i
//   advance : grant accepted this cycle, update last winner
//   gnt     : one-hot grant, or zero when nothing requested
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 means requester 1 won most recently; reset value makes 0 win a tie.
    logic last_reg;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (advance) begin
            last_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/sysid_ctrl.sv
// ---------------------------------------------------------------------------
// sysid_ctrl
// Boot-checks a sysid slave (ID at word 0, timestamp at word 1), then shares
// that slave between two read requesters with round-robin arbitration.
// Every accepted read returns one cycle later; the controller spends one
// RESP cycle per read, so peak throughput is one read every two cycles.
//   clock, reset                 : sole clock, asynchronous active-high reset
//   mN_read, mN_address          : requester N read request and word select
//   mN_waitrequest               : low only in the cycle mN's read is accepted
//   mN_readdatavalid, mN_readdata: one-cycle response pulse and held data
//   s_address, s_readdata        : sysid slave port (combinational read data)
//   boot_done, id_ok, ts_ok      : boot check status (status only, never
//                                  blocks serving)
//   serve_count                  : saturating count of reads served
// ---------------------------------------------------------------------------
module sysid_ctrl
    import sysid_ctrl_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID      = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS      = DEFAULT_EXPECTED_TS,
    // Reset value of serve_count; nonzero only to reach saturation quickly.
    parameter logic [15:0] SERVE_COUNT_INIT = 16'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_read,
    input  logic        m0_address,
    output logic        m0_waitrequest,
    output logic        m0_readdatavalid,
    output logic [31:0] m0_readdata,
    input  logic        m1_read,
    input  logic        m1_address,
    output logic        m1_waitrequest,
    output logic        m1_readdatavalid,
    output logic [31:0] m1_readdata,
    output logic        s_address,
    input  logic [31:0] s_readdata,
    output logic        boot_done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [15:0] serve_count
);

    state_e      state_reg;
    state_e      state_next;
    logic        grant_reg;          // requester being answered in RESP
    logic        boot_done_reg;
    logic        id_ok_reg;
    logic        ts_ok_reg;
    logic [15:0] serve_count_reg;

    logic [1:0]  read_vec;
    logic [1:0]  addr_vec;
    logic [1:0]  req_vec;
    logic [1:0]  gnt;
    logic        advance;
    logic [1:0]  wait_vec;
    logic [1:0]  rdv_vec;
    logic [31:0] rdata_reg [2];

    assign read_vec = {m1_read, m0_read};
    assign addr_vec = {m1_address, m0_address};

    // Requests are only visible to the arbiter in IDLE, so gnt is zero in
    // every other state and doubles as the "accept" strobe.
    assign req_vec = (state_reg == IDLE) ? read_vec : 2'b00;
    assign advance = |gnt;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req_vec),
        .advance (advance),
        .gnt     (gnt)
    );

    always_comb begin
        state_next = state_reg;
        s_address  = 1'b0;
        case (state_reg)
            BOOT_ID: begin
                s_address  = 1'b0;
                state_next = BOOT_TS;
            end
            BOOT_TS: begin
                s_address  = 1'b1;
                state_next = IDLE;
            end
            IDLE: begin
                if (gnt[0]) begin
                    s_address = addr_vec[0];
                end else if (gnt[1]) begin
                    s_address = addr_vec[1];
                end
                if (advance) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = BOOT_ID;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= BOOT_ID;
            grant_reg       <= 1'b0;
            boot_done_reg   <= 1'b0;
            id_ok_reg       <= 1'b0;
            ts_ok_reg       <= 1'b0;
            serve_count_reg <= SERVE_COUNT_INIT;
        end else begin
            state_reg <= state_next;
            if (state_reg == BOOT_ID) begin
                id_ok_reg <= (s_readdata == EXPECTED_ID);
            end
            if (state_reg == BOOT_TS) begin
                ts_ok_reg     <= (s_readdata == EXPECTED_TS);
                boot_done_reg <= 1'b1;
            end
            if (advance) begin
                grant_reg       <= gnt[1];
                serve_count_reg <= sat_inc16(serve_count_reg);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            // Data is captured in the accept cycle and held until the next
            // read for the same requester.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rdata_reg[gi] <= '0;
                end else if (gnt[gi]) begin
                    rdata_reg[gi] <= s_readdata;
                end
            end

            assign wait_vec[gi] = ~gnt[gi];
            // Decoded from state, so an asynchronous reset during RESP
            // removes the pulse immediately.
            assign rdv_vec[gi]  = (state_reg == RESP) && (grant_reg == 1'(gi));
        end
    endgenerate

    assign m0_waitrequest   = wait_vec[0];
    assign m1_waitrequest   = wait_vec[1];
    assign m0_readdatavalid = rdv_vec[0];
    assign m1_readdatavalid = rdv_vec[1];
    assign m0_readdata      = rdata_reg[0];
    assign m1_readdata      = rdata_reg[1];
    assign boot_done        = boot_done_reg;
    assign id_ok            = id_ok_reg;
    assign ts_ok            = ts_ok_reg;
    assign serve_count      = serve_count_reg;

endmodule

// File: tb/tb_sysid_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sysid_ctrl
// Drives both requesters every cycle and compares all outputs with a
// transaction-level reference model (boot phase, pending response, last
// tie winner, saturating counts). A second instance starts its serve
// counter near the top so the saturation path is reached in a short run.
// ---------------------------------------------------------------------------
module tb_sysid_ctrl;

    localparam logic [31:0] EXP_ID = 32'd452;
    localparam logic [31:0] EXP_TS = 32'd1301991580;
    localparam int          B_INIT = 65530;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_read = 1'b0, m0_address = 1'b0;
    logic        m1_read = 1'b0, m1_address = 1'b0;
    logic        m0_waitrequest, m0_readdatavalid;
    logic        m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_address;
    logic [31:0] s_readdata;
    logic        boot_done, id_ok, ts_ok;
    logic [15:0] serve_count;

    logic        b_m0_waitrequest, b_m0_readdatavalid;
    logic        b_m1_waitrequest, b_m1_readdatavalid;
    logic [31:0] b_m0_readdata, b_m1_readdata;
    logic        b_s_address;
    logic [31:0] b_s_readdata;
    logic        b_boot_done, b_id_ok, b_ts_ok;
    logic [15:0] b_serve_count;

    logic [31:0] id_val = EXP_ID;
    logic [31:0] ts_val = EXP_TS;

    always #5 clock = ~clock;

    // Sysid slave model: word 0 = ID, word 1 = timestamp.
    always_comb s_readdata   = s_address   ? ts_val : id_val;
    always_comb b_s_readdata = b_s_address ? ts_val : id_val;

    sysid_ctrl dut (
        .clock(clock), .reset(reset),
        .m0_read(m0_read), .m0_address(m0_address),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
        .m0_readdata(m0_readdata),
        .m1_read(m1_read), .m1_address(m1_address),
        .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
        .m1_readdata(m1_readdata),
        .s_address(s_address), .s_readdata(s_readdata),
        .boot_done(boot_done), .id_ok(id_ok), .ts_ok(ts_ok),
        .serve_count(serve_count)
    );

    sysid_ctrl #(.SERVE_COUNT_INIT(16'(B_INIT))) dut_b (
        .clock(clock), .reset(reset),
        .m0_read(m0_read), .m0_address(m0_address),
        .m0_waitrequest(b_m0_waitrequest), .m0_readdatavalid(b_m0_readdatavalid),
        .m0_readdata(b_m0_readdata),
        .m1_read(m1_read), .m1_address(m1_address),
        .m1_waitrequest(b_m1_waitrequest), .m1_readdatavalid(b_m1_readdatavalid),
        .m1_readdata(b_m1_readdata),
        .s_address(b_s_address), .s_readdata(b_s_readdata),
        .boot_done(b_boot_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
        .serve_count(b_serve_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          phase;      // 0: ID check next, 1: TS check next, 2: serving
    int          resp_who;   // requester answered this cycle, -1 if none
    int          last_win;   // most recent winner, 1 after reset
    logic [31:0] m_rd [2];
    bit          m_id_ok, m_ts_ok, m_done;
    int          m_cnt, m_cnt_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase    = 0;
        resp_who = -1;
        last_win = 1;
        m_rd[0]  = '0;
        m_rd[1]  = '0;
        m_id_ok  = 0;
        m_ts_ok  = 0;
        m_done   = 0;
        m_cnt    = 0;
        m_cnt_b  = B_INIT;
    endtask

    // One clock cycle: apply inputs at negedge, check 1 time unit later,
    // then advance the model to what the next rising edge will produce.
    task automatic cycle(input bit rst, input bit r0, input bit a0, input bit r1, input bit a1);
        int w;
        bit wa;
        @(negedge clock);
        reset = rst; m0_read = r0; m0_address = a0; m1_read = r1; m1_address = a1;
        #1;
        if (rst) model_reset();
        w = -1;
        if (!rst && phase == 2 && resp_who < 0) begin
            if (r0 && r1)  w = (last_win == 0) ? 1 : 0;
            else if (r0)   w = 0;
            else if (r1)   w = 1;
        end
        chk("m0_waitrequest",   32'(m0_waitrequest),   (w == 0) ? 32'd0 : 32'd1);
        chk("m1_waitrequest",   32'(m1_waitrequest),   (w == 1) ? 32'd0 : 32'd1);
        chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(resp_who == 0));
        chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(resp_who == 1));
        chk("m0_readdata", m0_readdata, m_rd[0]);
        chk("m1_readdata", m1_readdata, m_rd[1]);
        chk("boot_done",   32'(boot_done), 32'(m_done));
        chk("id_ok",       32'(id_ok),     32'(m_id_ok));
        chk("ts_ok",       32'(ts_ok),     32'(m_ts_ok));
        chk("serve_count",   32'(serve_count),   32'(m_cnt));
        chk("serve_count_b", 32'(b_serve_count), 32'(m_cnt_b));
        if (phase == 0)                   chk("s_address_boot_id", 32'(s_address), 32'd0);
        else if (phase == 1)              chk("s_address_boot_ts", 32'(s_address), 32'd1);
        else if (w >= 0)                  chk("s_address_grant",   32'(s_address), 32'((w == 1) ? a1 : a0));
        else if (resp_who < 0)            chk("s_address_idle",    32'(s_address), 32'd0);
        if (!rst) begin
            if (phase == 0) begin
                m_id_ok = (id_val == EXP_ID);
                phase   = 1;
            end else if (phase == 1) begin
                m_ts_ok = (ts_val == EXP_TS);
                m_done  = 1;
                phase   = 2;
            end else if (resp_who >= 0) begin
                resp_who = -1;
            end else if (w >= 0) begin
                wa       = (w == 1) ? a1 : a0;
                m_rd[w]  = wa ? ts_val : id_val;
                m_cnt    = (m_cnt   < 65535) ? m_cnt   + 1 : 65535;
                m_cnt_b  = (m_cnt_b < 65535) ? m_cnt_b + 1 : 65535;
                last_win = w;
                resp_who = w;
            end
        end
    endtask

    initial begin
        bit found;
        model_reset();

        // Reset state
        repeat (3) cycle(1, 0, 0, 0, 0);

        // Correct boot, m0 timestamp read held from reset release
        repeat (8) cycle(0, 1, 1, 0, 0);

        // Wrong ID: flagged but reads still served with the slave's value
        id_val = 32'd451;
        repeat (2) cycle(1, 0, 0, 0, 0);
        repeat (8) cycle(0, 1, 0, 0, 0);

        // Both requesters continuous: alternating grants
        id_val = EXP_ID;
        repeat (2) cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, i[0], 1, ~i[0]);

        // Randomized traffic with randomized slave contents
        for (int k = 0; k < 3; k++) begin
            id_val = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            ts_val = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            repeat (2) cycle(1, 0, 0, 0, 0);
            for (int i = 0; i < 100; i++)
                cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset asserted during a response cycle
        id_val = EXP_ID;
        ts_val = EXP_TS;
        found  = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (resp_who >= 0) found = 1;
            else cycle(0, 1, 1, 1, 0);
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $error("FAIL resp_wait observed=timeout expected=resp_cycle");
        end
        cycle(1, 1, 1, 1, 0);
        cycle(1, 0, 0, 0, 0);

        // Saturation: second instance starts at 65530 and sees ~20 grants
        for (int i = 0; i < 40; i++) cycle(0, 1, 1'($urandom), 1, 1'($urandom));
        chk("serve_count_b_saturated", 32'(b_serve_count), 32'd65535);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
